// File: rtl/bram_scan_capture.sv
// 8x8 preset single-port block RAM with a free-running address sweep and a
// trigger-armed buffer that records the streamed {address, data} pairs.
module bram_scan_capture #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int CAP_DEPTH = 16,
    parameter int CAP_AW    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ena,
    input  logic                     wea,
    input  logic [ADDR_W-1:0]        addra,
    input  logic [DATA_W-1:0]        dina,
    input  logic                     scan_en,
    output logic [DATA_W-1:0]        douta,
    output logic [ADDR_W-1:0]        douta_addr,
    output logic                     douta_valid,
    input  logic                     cap_arm,
    input  logic [DATA_W-1:0]        cap_trig_val,
    input  logic [CAP_AW-1:0]        cap_rd_addr,
    output logic [ADDR_W+DATA_W-1:0] cap_rd_data,
    output logic                     cap_armed,
    output logic                     cap_done,
    output logic [1:0]               cap_state_dbg
);

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_CAPTURE = 2'd2,
        CAP_DONE    = 2'd3
    } cap_state_t;

    // Power-up contents are the configuration image; reset never touches them.
    logic [DATA_W-1:0]        mem_q [2**ADDR_W] = '{8'h00, 8'h3E, 8'h00, 8'h0C,
                                                    8'h00, 8'h18, 8'h00, 8'h60};
    logic [ADDR_W+DATA_W-1:0] cap_buf_q [CAP_DEPTH] = '{default: '0};

    logic [DATA_W-1:0] douta_q;
    logic [ADDR_W-1:0] douta_addr_q;
    logic              douta_valid_q;
    logic [ADDR_W-1:0] scan_q;
    logic [ADDR_W-1:0] eff_addr;
    logic              mem_we;

    cap_state_t               state_q, state_d;
    logic [CAP_AW-1:0]        idx_q, idx_d;
    logic                     buf_we;
    logic [CAP_AW-1:0]        buf_wa;

    assign eff_addr = scan_en ? scan_q : addra;
    assign mem_we   = ena && wea && !scan_en && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[eff_addr] <= dina;
        end
    end

    // Write-first: a committing write is reflected on douta at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            douta_q       <= '0;
            douta_addr_q  <= '0;
            douta_valid_q <= 1'b0;
            scan_q        <= '0;
        end else begin
            douta_valid_q <= ena;
            if (ena) begin
                douta_q      <= mem_we ? dina : mem_q[eff_addr];
                douta_addr_q <= eff_addr;
                if (scan_en) begin
                    scan_q <= scan_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CAP_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_we  = 1'b0;
        buf_wa  = idx_q;
        case (state_q)
            CAP_IDLE, CAP_DONE: begin
                if (cap_arm) begin
                    state_d = CAP_ARMED;
                    idx_d   = '0;
                end
            end
            CAP_ARMED: begin
                if (douta_valid_q && (douta_q == cap_trig_val)) begin
                    buf_we  = 1'b1;
                    buf_wa  = '0;
                    idx_d   = CAP_AW'(1);
                    state_d = CAP_CAPTURE;
                end
            end
            CAP_CAPTURE: begin
                if (douta_valid_q) begin
                    buf_we = 1'b1;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == CAP_AW'(CAP_DEPTH - 1)) begin
                        state_d = CAP_DONE;
                    end
                end
            end
            default: state_d = CAP_IDLE;
        endcase
    end

    // Buffer has no reset so a capture survives a board reset for readout.
    always_ff @(posedge clk) begin
        if (buf_we && !reset) begin
            cap_buf_q[buf_wa] <= {douta_addr_q, douta_q};
        end
    end

    assign douta         = douta_q;
    assign douta_addr    = douta_addr_q;
    assign douta_valid   = douta_valid_q;
    assign cap_rd_data   = cap_buf_q[cap_rd_addr];
    assign cap_armed     = (state_q == CAP_ARMED);
    assign cap_done      = (state_q == CAP_DONE);
    assign cap_state_dbg = state_q;

endmodule

// File: tb/tb_bram_scan_capture.sv
// Directed bench for bram_scan_capture: sweep, hold, reset, capture and write paths.
module tb_bram_scan_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ena = 1'b0;
    logic        wea = 1'b0;
    logic [2:0]  addra = '0;
    logic [7:0]  dina = '0;
    logic        scan_en = 1'b0;
    logic [7:0]  douta;
    logic [2:0]  douta_addr;
    logic        douta_valid;
    logic        cap_arm = 1'b0;
    logic [7:0]  cap_trig_val = '0;
    logic [3:0]  cap_rd_addr = '0;
    logic [10:0] cap_rd_data;
    logic        cap_armed;
    logic        cap_done;
    logic [1:0]  cap_state_dbg;

    int checks = 0;
    int failures = 0;

    logic [7:0] preset [8] = '{8'h00, 8'h3E, 8'h00, 8'h0C, 8'h00, 8'h18, 8'h00, 8'h60};

    bram_scan_capture dut (
        .clk(clk), .reset(reset), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .scan_en(scan_en), .douta(douta), .douta_addr(douta_addr), .douta_valid(douta_valid),
        .cap_arm(cap_arm), .cap_trig_val(cap_trig_val), .cap_rd_addr(cap_rd_addr),
        .cap_rd_data(cap_rd_data), .cap_armed(cap_armed), .cap_done(cap_done),
        .cap_state_dbg(cap_state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; scan_en = 1'b1; ena = 1'b1;
        tick();
        checks++;
        if (douta !== 8'h00 || douta_addr !== 3'd0 || douta_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: douta=%h addr=%0d valid=%b, want 00/0/0", douta, douta_addr, douta_valid);
        end
        checks++;
        if (cap_armed !== 1'b0 || cap_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_cap: armed=%b done=%b, want 0/0", cap_armed, cap_done);
        end
        cap_rd_addr = 4'd0; #1;
        checks++;
        if (cap_rd_data !== 11'h000) begin
            failures++;
            $display("FAIL reset_buf: entry0=%h, want 000", cap_rd_data);
        end
        reset = 1'b0;
    endtask

    // Two sweeps with wea/dina active to show scan mode stays read-only.
    task automatic test_scan();
        wea = 1'b1; dina = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (douta !== preset[i % 8] || douta_addr !== 3'(i % 8) || douta_valid !== 1'b1) begin
                failures++;
                $display("FAIL scan_%0d: douta=%h addr=%0d valid=%b, want %h/%0d/1",
                         i, douta, douta_addr, douta_valid, preset[i % 8], i % 8);
            end
        end
        wea = 1'b0;
    endtask

    task automatic test_ena_hold();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (douta !== 8'h3E || douta_addr !== 3'd1 || douta_valid !== 1'b0) begin
                failures++;
                $display("FAIL ena_hold_%0d: douta=%h addr=%0d valid=%b, want 3e/1/0",
                         i, douta, douta_addr, douta_valid);
            end
        end
        ena = 1'b1;
        tick();
        checks++;
        if (douta !== 8'h00 || douta_addr !== 3'd2 || douta_valid !== 1'b1) begin
            failures++;
            $display("FAIL ena_resume: douta=%h addr=%0d valid=%b, want 00/2/1", douta, douta_addr, douta_valid);
        end
        tick();
        checks++;
        if (douta !== 8'h0C || douta_addr !== 3'd3) begin
            failures++;
            $display("FAIL ena_resume2: douta=%h addr=%0d, want 0c/3", douta, douta_addr);
        end
    endtask

    task automatic test_reset_mid_sweep();
        tick(); tick(); tick();
        checks++;
        if (douta !== 8'h00 || douta_addr !== 3'd6) begin
            failures++;
            $display("FAIL mid_pre: douta=%h addr=%0d, want 00/6", douta, douta_addr);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (douta !== 8'h00 || douta_addr !== 3'd0 || douta_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: douta=%h addr=%0d valid=%b, want 00/0/0", douta, douta_addr, douta_valid);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (douta !== 8'h00 || douta_addr !== 3'd0 || douta_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_first: douta=%h addr=%0d valid=%b, want 00/0/1", douta, douta_addr, douta_valid);
        end
        tick();
        checks++;
        if (douta !== 8'h3E || douta_addr !== 3'd1) begin
            failures++;
            $display("FAIL mid_second: douta=%h addr=%0d, want 3e/1", douta, douta_addr);
        end
    endtask

    task automatic check_capture_buffer(input string tag);
        for (int k = 0; k < 16; k++) begin
            logic [2:0] a;
            a = 3'((3 + k) % 8);
            cap_rd_addr = 4'(k); #1;
            checks++;
            if (cap_rd_data !== {a, preset[a]}) begin
                failures++;
                $display("FAIL %s_entry%0d: got %h, want %h", tag, k, cap_rd_data, {a, preset[a]});
            end
        end
    endtask

    task automatic test_capture();
        reset = 1'b1;
        tick();
        reset = 1'b0; cap_trig_val = 8'h0C; cap_arm = 1'b1;
        tick();
        cap_arm = 1'b0;
        checks++;
        if (cap_armed !== 1'b1 || cap_done !== 1'b0) begin
            failures++;
            $display("FAIL cap_arm: armed=%b done=%b, want 1/0", cap_armed, cap_done);
        end
        tick(); tick(); tick();
        checks++;
        if (cap_armed !== 1'b1 || douta !== 8'h0C) begin
            failures++;
            $display("FAIL cap_wait: armed=%b douta=%h, want 1/0c", cap_armed, douta);
        end
        tick();
        checks++;
        if (cap_armed !== 1'b0 || cap_done !== 1'b0 || cap_state_dbg !== 2'd2) begin
            failures++;
            $display("FAIL cap_trig: armed=%b done=%b state=%0d, want 0/0/2", cap_armed, cap_done, cap_state_dbg);
        end
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (cap_done !== 1'b0) begin
            failures++;
            $display("FAIL cap_early_done: done=%b, want 0", cap_done);
        end
        tick();
        checks++;
        if (cap_done !== 1'b1 || cap_armed !== 1'b0) begin
            failures++;
            $display("FAIL cap_done: done=%b armed=%b, want 1/0", cap_done, cap_armed);
        end
        check_capture_buffer("cap");
        cap_trig_val = 8'h77; cap_arm = 1'b1;
        tick();
        cap_arm = 1'b0;
        checks++;
        if (cap_armed !== 1'b1 || cap_done !== 1'b0) begin
            failures++;
            $display("FAIL cap_rearm: armed=%b done=%b, want 1/0", cap_armed, cap_done);
        end
    endtask

    task automatic test_no_trigger();
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (cap_armed !== 1'b1 || cap_done !== 1'b0) begin
            failures++;
            $display("FAIL notrig_state: armed=%b done=%b, want 1/0", cap_armed, cap_done);
        end
        check_capture_buffer("notrig");
    endtask

    task automatic test_write();
        scan_en = 1'b0; ena = 1'b1; wea = 1'b1; addra = 3'd5; dina = 8'hA5;
        tick();
        checks++;
        if (douta !== 8'hA5 || douta_addr !== 3'd5 || douta_valid !== 1'b1) begin
            failures++;
            $display("FAIL wr_first: douta=%h addr=%0d valid=%b, want a5/5/1", douta, douta_addr, douta_valid);
        end
        wea = 1'b0; dina = 8'h00;
        tick();
        checks++;
        if (douta !== 8'hA5) begin
            failures++;
            $display("FAIL wr_readback: douta=%h, want a5", douta);
        end
        addra = 3'd3;
        tick();
        checks++;
        if (douta !== 8'h0C || douta_addr !== 3'd3) begin
            failures++;
            $display("FAIL wr_other: douta=%h addr=%0d, want 0c/3", douta, douta_addr);
        end
        ena = 1'b0; wea = 1'b1; dina = 8'hFF;
        tick();
        checks++;
        if (douta !== 8'h0C || douta_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_ena_off: douta=%h valid=%b, want 0c/0", douta, douta_valid);
        end
        ena = 1'b1; reset = 1'b1;
        tick();
        checks++;
        if (douta !== 8'h00 || douta_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_reset: douta=%h valid=%b, want 00/0", douta, douta_valid);
        end
        reset = 1'b0; wea = 1'b0;
        tick();
        checks++;
        if (douta !== 8'h0C || douta_addr !== 3'd3) begin
            failures++;
            $display("FAIL wr_blocked: douta=%h addr=%0d, want 0c/3", douta, douta_addr);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_ena_hold();
        test_reset_mid_sweep();
        test_capture();
        test_no_trigger();
        test_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_scan_capture.md
Name: bram_scan_capture

Overview:
- Single-port 8x8 synchronous block RAM with preset contents and a built-in address sequencer that sweeps all locations continuously.
- Includes a trigger-armed capture buffer that records the streamed {address, data} pairs for later readout.
- Sits between board-level debug control (reset/arm sources) and on-chip monitoring logic.

Parameters:
- DATA_W, 8, data word width.
- ADDR_W, 3, RAM address width; depth = 2**ADDR_W = 8.
- CAP_DEPTH, 16, capture buffer entries (power of two).
- CAP_AW, 4, log2(CAP_DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ena  in  1  RAM port enable.
- wea  in  1  write enable; honoured only when ena=1 and scan_en=0.
- addra  in  ADDR_W  external address, used when scan_en=0.
- dina  in  DATA_W  write data.
- scan_en  in  1  1 = internal counter drives the address, RAM read-only.
- douta  out  DATA_W  registered read data.
- douta_addr  out  ADDR_W  address that produced the current douta.
- douta_valid  out  1  douta updated by the previous edge.
- cap_arm  in  1  arm capture (single-cycle pulse).
- cap_trig_val  in  DATA_W  trigger data value.
- cap_rd_addr  in  CAP_AW  capture buffer read index.
- cap_rd_data  out  ADDR_W+DATA_W  {addr, data} entry at cap_rd_addr; combinational.
- cap_armed  out  1  state is ARMED.
- cap_done  out  1  state is DONE.

Behaviour:
- Memory contents at configuration/power-up, addresses 0..7: 0x00, 0x3E, 0x00, 0x0C, 0x00, 0x18, 0x00, 0x60.
- Reset never alters memory contents.
- Memory writes are blocked in any cycle where reset=1.
- Reset values: douta=0, douta_addr=0, douta_valid=0, scan counter=0, capture state IDLE, write index=0, cap_armed=0, cap_done=0.
- Effective address: scan counter when scan_en=1, otherwise addra.
- Read latency is 1 cycle. If ena=1 at an edge, then after that edge:
  - douta = mem[eff addr]
  - douta_addr = eff addr
  - douta_valid = 1
- If ena=0 at an edge: douta and douta_addr hold, douta_valid=0, no write.
- Write occurs when ena=1, wea=1, scan_en=0 and reset=0. Write-first mode: douta shows dina on the same edge the write commits.
- With scan_en=1, wea is ignored.
- Scan counter:
  - Increments by 1 on each edge where scan_en=1, ena=1 and reset=0.
  - Wraps 7 -> 0 (modulo 2**ADDR_W).
  - Holds otherwise.
  - Returns to 0 on reset, including mid-sweep.
- Capture FSM, states IDLE / ARMED / CAPTURE / DONE:
  - IDLE or DONE, cap_arm=1 -> ARMED. Clears cap_done and write index.
  - ARMED, douta_valid=1 and douta==cap_trig_val -> writes {douta_addr, douta} to entry 0, index=1, goes to CAPTURE.
  - CAPTURE: writes one entry per cycle in which douta_valid=1. Cycles with douta_valid=0 are skipped.
  - CAPTURE -> DONE after entry CAP_DEPTH-1 is written.
  - cap_arm is ignored in ARMED and CAPTURE.
  - Reset in any state -> IDLE; buffer contents are preserved.
- cap_rd_data reads the buffer at any time. Entries never written since power-up read as 0.

Test Plan:
- Reset 1 cycle, then scan_en=1, ena=1, wea=0 -> from the first edge after reset release douta follows 00,3E,00,0C,00,18,00,60,00,3E…; douta_addr follows 0,1,…,7,0,1…; douta_valid=1 throughout.
- scan_en=0, ena=1, wea=1, addra=5, dina=0xA5 for one cycle -> douta=0xA5 on that edge. Then wea=0, addra=5 -> douta=0xA5. Then addra=3 -> douta=0x0C.
- Scan running, drop ena to 0 for 3 cycles -> douta and douta_addr frozen, douta_valid=0, counter held. Re-assert ena -> sequence resumes at the next address.
- Reset asserted while douta_addr=6 -> outputs cleared. The first read after release is address 0 (0x00), then address 1 (0x3E).
- Scan from reset, cap_trig_val=0x0C, pulse cap_arm -> entry0 = {3,0x0C}, entry1 = {4,0x00}, entry2 = {5,0x18}, entry3 = {6,0x00}, entry4 = {7,0x60}, entry5 = {0,0x00}, …, entry15 = {2,0x00}. cap_done=1 after 16 entries; a further cap_arm pulse re-arms.
- cap_arm with cap_trig_val=0x77 (no matching data) -> cap_armed stays 1, cap_done stays 0, buffer unchanged.
